// File: rtl/fbuf_bank_writer_if.sv
// Capture-FIFO / frame-buffer write-port bundle for fbuf_bank_writer.
// master = the bank writer, slave = the surrounding FIFO, BRAM and reader logic.
interface fbuf_bank_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 19,
  parameter int BW         = 1
);
  logic                  i_flush;
  logic                  i_enable;
  logic                  o_rd;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_sof;
  logic                  i_almostempty;
  logic                  o_mem_wr;
  logic [AW-1:0]         o_mem_waddr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_rd_lock;
  logic [BW-1:0]         i_rd_bank;
  logic [BW-1:0]         o_wr_bank;
  logic [BW-1:0]         o_done_bank;
  logic                  o_frame_done;
  logic                  o_frame_err;
  logic                  o_frame_drop;

  modport master (
    input  i_flush, i_enable, i_rdata, i_sof, i_almostempty, i_rd_lock, i_rd_bank,
    output o_rd, o_mem_wr, o_mem_waddr, o_mem_wdata, o_wr_bank, o_done_bank,
           o_frame_done, o_frame_err, o_frame_drop
  );

  modport slave (
    output i_flush, i_enable, i_rdata, i_sof, i_almostempty, i_rd_lock, i_rd_bank,
    input  o_rd, o_mem_wr, o_mem_waddr, o_mem_wdata, o_wr_bank, o_done_bank,
           o_frame_done, o_frame_err, o_frame_drop
  );
endinterface

// File: rtl/fbuf_bank_writer.sv
// Drains a FWFT pixel FIFO into an N-bank frame buffer, aligning on SOF and
// rotating banks per completed frame while avoiding the bank the reader holds.
module fbuf_bank_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_DEPTH = 230400,
  parameter int NUM_BANKS   = 2
) (
  input logic            i_clk,
  input logic            i_rstn,
  fbuf_bank_writer_if.master bus
);
  localparam int AW = $clog2(FRAME_DEPTH * NUM_BANKS);
  localparam int BW = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
  localparam int CW = (FRAME_DEPTH > 2) ? $clog2(FRAME_DEPTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(FRAME_DEPTH - 1);
  localparam logic [BW-1:0] BANK_MAX = BW'(NUM_BANKS - 1);

  typedef enum logic [1:0] {SYNC, ACTIVE, EXPECT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt, wcount;
  logic          wr_nxt, done_nxt, err_nxt, drop;
  logic [BW-1:0] cand1, cand2;
  logic [AW-1:0] waddr_nxt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= SYNC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.i_flush) state_nxt = SYNC;
    else if (bus.o_rd) begin
      case (state)
        SYNC:    if (bus.i_sof) state_nxt = ACTIVE;
        ACTIVE:  if (!bus.i_sof && count == LAST) state_nxt = EXPECT;
        EXPECT:  state_nxt = bus.i_sof ? ACTIVE : SYNC;
        default: state_nxt = SYNC;
      endcase
    end
  end

  // wcount is the in-bank offset of the word popped this cycle; a SOF always lands at 0.
  always_comb begin
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    count_nxt = count;
    wcount    = count;
    if (bus.i_flush) count_nxt = '0;
    else if (bus.o_rd) begin
      case (state)
        SYNC: if (bus.i_sof) begin
          wr_nxt    = 1'b1;
          wcount    = '0;
          count_nxt = CW'(1);
        end
        ACTIVE: begin
          wr_nxt = 1'b1;
          if (bus.i_sof) begin
            err_nxt   = 1'b1;
            wcount    = '0;
            count_nxt = CW'(1);
          end else if (count == LAST) begin
            done_nxt  = 1'b1;
            count_nxt = '0;
          end else count_nxt = count + CW'(1);
        end
        EXPECT: if (bus.i_sof) begin
          wr_nxt    = 1'b1;
          wcount    = '0;
          count_nxt = CW'(1);
        end else err_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  // Next bank skips the reader's bank once; landing back on ourselves or the locked bank means no free bank.
  always_comb begin
    cand1 = (bus.o_wr_bank == BANK_MAX) ? '0 : bus.o_wr_bank + BW'(1);
    cand2 = cand1;
    if (bus.i_rd_lock && cand1 == bus.i_rd_bank)
      cand2 = (cand1 == BANK_MAX) ? '0 : cand1 + BW'(1);
    drop = (cand2 == bus.o_wr_bank) || (bus.i_rd_lock && cand2 == bus.i_rd_bank);
    waddr_nxt = AW'(bus.o_wr_bank) * AW'(FRAME_DEPTH) + AW'(wcount);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bus.o_rd         <= 1'b0;
      bus.o_mem_wr     <= 1'b0;
      bus.o_mem_waddr  <= '0;
      bus.o_mem_wdata  <= '0;
      bus.o_wr_bank    <= '0;
      bus.o_done_bank  <= '0;
      bus.o_frame_done <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_frame_drop <= 1'b0;
      count            <= '0;
    end else begin
      bus.o_rd         <= bus.i_enable & ~bus.i_almostempty & ~bus.i_flush;
      bus.o_mem_wr     <= wr_nxt;
      bus.o_frame_done <= done_nxt;
      bus.o_frame_err  <= err_nxt;
      bus.o_frame_drop <= done_nxt & drop;
      count            <= count_nxt;
      if (wr_nxt) begin
        bus.o_mem_waddr <= waddr_nxt;
        bus.o_mem_wdata <= bus.i_rdata;
      end
      if (done_nxt) begin
        bus.o_done_bank <= bus.o_wr_bank;
        if (!drop) bus.o_wr_bank <= cand2;
      end
    end
  end
endmodule

// File: tb/tb_fbuf_bank_writer.sv
// Scoreboard bench: a 3-bank writer is fully checked against expected writes; a 2-bank
// twin on the same FIFO stream covers the no-free-bank drop case.
module tb_fbuf_bank_writer;
  logic clk, rstn;

  fbuf_bank_writer_if #(.DATA_WIDTH(16), .AW(6), .BW(2)) bus_a();
  fbuf_bank_writer_if #(.DATA_WIDTH(16), .AW(5), .BW(1)) bus_b();

  fbuf_bank_writer #(.DATA_WIDTH(16), .FRAME_DEPTH(16), .NUM_BANKS(3)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .bus(bus_a));
  fbuf_bank_writer #(.DATA_WIDTH(16), .FRAME_DEPTH(16), .NUM_BANKS(2)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .bus(bus_b));

  assign bus_b.i_rdata       = bus_a.i_rdata;
  assign bus_b.i_sof         = bus_a.i_sof;
  assign bus_b.i_almostempty = bus_a.i_almostempty;
  assign bus_b.i_flush       = bus_a.i_flush;
  assign bus_b.i_enable      = bus_a.i_enable;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [5:0] addr; logic [15:0] data; logic done; logic [1:0] dbank; } exp_t;
  typedef struct { logic sof; logic [15:0] data; } word_t;

  exp_t  exp_q[$];
  word_t src[$];
  int    checks = 0, errors = 0;
  int    err_cnt = 0, drop_a = 0, drop_b = 0;
  logic  pend = 1'b0, hold_ae = 1'b0;
  logic [4:0] b_last = '0;

  // FWFT source: almostempty guarantees a valid head for every pop already in flight.
  task automatic drive_src();
    if (src.size() > 0) begin
      bus_a.i_rdata = src[0].data;
      bus_a.i_sof   = src[0].sof;
    end else begin
      bus_a.i_rdata = '0;
      bus_a.i_sof   = 1'b0;
    end
    bus_a.i_almostempty = hold_ae || (src.size() <= (pend ? 1 : 0));
  endtask

  task automatic push_word(input logic sof, input logic [15:0] data);
    word_t w;
    w.sof = sof; w.data = data;
    src.push_back(w);
  endtask

  task automatic push_exp(input int addr, input logic [15:0] data, input logic done, input int bank);
    exp_t e;
    e.addr = 6'(addr); e.data = data; e.done = done; e.dbank = 2'(bank);
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int bank, input logic [15:0] base);
    for (int i = 0; i < 16; i++) begin
      push_word(i == 0, base + 16'(i));
      push_exp(bank * 16 + i, base + 16'(i), i == 15, bank);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    checks++;
    if (bus_a.o_mem_wr) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", bus_a.o_mem_waddr, bus_a.o_mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus_a.o_mem_waddr !== e.addr || bus_a.o_mem_wdata !== e.data || bus_a.o_frame_done !== e.done) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h done=%0b want addr=%0h data=%0h done=%0b",
                   bus_a.o_mem_waddr, bus_a.o_mem_wdata, bus_a.o_frame_done, e.addr, e.data, e.done);
        end
        if (e.done) begin
          checks++;
          if (bus_a.o_done_bank !== e.dbank) begin
            errors++;
            $display("FAIL done_bank got=%0d want=%0d", bus_a.o_done_bank, e.dbank);
          end
        end
      end
    end else if (bus_a.o_frame_done) begin
      errors++;
      $display("FAIL frame_done_without_write got=1 want=0");
    end
    if (bus_a.o_frame_err)  err_cnt++;
    if (bus_a.o_frame_drop) drop_a++;
    if (bus_b.o_frame_drop) drop_b++;
    if (bus_b.o_mem_wr)     b_last = bus_b.o_mem_waddr;
    if (pend && src.size() > 0) void'(src.pop_front());
    pend = bus_a.o_rd;
    drive_src();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || src.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s drain_timeout pending_writes=%0d want=0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    chk("rst_rd", bus_a.o_rd, 0);
    chk("rst_wr", bus_a.o_mem_wr, 0);
    chk("rst_waddr", bus_a.o_mem_waddr, 0);
    chk("rst_wr_bank", bus_a.o_wr_bank, 0);
    chk("rst_done_bank", bus_a.o_done_bank, 0);
    chk("rst_pulses", {bus_a.o_frame_done, bus_a.o_frame_err, bus_a.o_frame_drop}, 0);
    rstn = 1'b1;
    repeat (2) tick();
    chk("idle_rd_empty_fifo", bus_a.o_rd, 0);
  endtask

  task automatic test_clean_frames();
    push_frame(0, 16'h1000);
    push_frame(1, 16'h1100);
    drain("clean");
    chk("clean_wr_bank", bus_a.o_wr_bank, 2);
    chk("clean_err", err_cnt, 0);
  endtask

  task automatic test_garbage();
    int e0 = err_cnt;
    for (int i = 0; i < 3; i++) push_word(1'b0, 16'hE000 + 16'(i));
    push_frame(2, 16'h2000);
    drain("garbage");
    chk("garbage_err", err_cnt - e0, 1);
    chk("garbage_bank_wrap", bus_a.o_wr_bank, 0);
  endtask

  task automatic test_early_sof();
    int e0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      push_word(i == 0, 16'h3000 + 16'(i));
      push_exp(i, 16'h3000 + 16'(i), 1'b0, 0);
    end
    for (int i = 0; i < 16; i++) begin
      push_word(i == 0, 16'h3100 + 16'(i));
      push_exp(i, 16'h3100 + 16'(i), i == 15, 0);
    end
    drain("early_sof");
    chk("early_sof_err", err_cnt - e0, 1);
    chk("early_sof_bank", bus_a.o_wr_bank, 1);
  endtask

  task automatic test_lock();
    int da = drop_a, db = drop_b;
    bus_a.i_rd_lock = 1'b1; bus_a.i_rd_bank = 2'd2;
    bus_b.i_rd_lock = 1'b1; bus_b.i_rd_bank = 1'b1;
    push_frame(1, 16'h4000);
    drain("lock");
    chk("lock3_skip_bank", bus_a.o_wr_bank, 0);
    chk("lock3_no_drop", drop_a - da, 0);
    chk("lock2_drop", drop_b - db, 1);
    chk("lock2_wr_bank_kept", bus_b.o_wr_bank, 0);
    chk("lock2_done_bank", bus_b.o_done_bank, 0);
    chk("lock2_last_addr", b_last, 15);
    bus_a.i_rd_lock = 1'b0; bus_a.i_rd_bank = '0;
    bus_b.i_rd_lock = 1'b0; bus_b.i_rd_bank = '0;
  endtask

  task automatic test_flush();
    int e0 = err_cnt;
    for (int i = 0; i < 10; i++) push_word(i == 0, 16'h5000 + 16'(i));
    for (int i = 0; i < 7; i++) push_exp(i, 16'h5000 + 16'(i), 1'b0, 0);
    drive_src();
    repeat (8) tick();
    bus_a.i_flush = 1'b1;
    tick();
    chk("flush_rd_off", bus_a.o_rd, 0);
    chk("flush_wr_off", bus_a.o_mem_wr, 0);
    chk("flush_wr_bank_kept", bus_a.o_wr_bank, 0);
    chk("flush_done_bank_kept", bus_a.o_done_bank, 1);
    bus_a.i_flush = 1'b0;
    drive_src();
    drain("flush_tail");
    chk("flush_sync_silent", err_cnt - e0, 0);
    push_frame(0, 16'h5100);
    drain("flush_resync");
    chk("flush_next_bank", bus_a.o_wr_bank, 1);
  endtask

  task automatic test_almostempty();
    int n = 0;
    logic ae_prev;
    push_frame(1, 16'h6000);
    while (exp_q.size() > 0 && n < 300) begin
      ae_prev = bus_a.i_almostempty;
      tick();
      checks++;
      if (bus_a.o_rd && ae_prev) begin
        errors++;
        $display("FAIL ae_pop got rd=1 want rd=0 (cycle %0d)", n);
      end
      n++;
      if (n % 3 == 0) begin
        hold_ae = ~hold_ae;
        drive_src();
      end
    end
    hold_ae = 1'b0;
    drive_src();
    drain("almostempty");
    chk("ae_bank", bus_a.o_wr_bank, 2);
  endtask

  task automatic test_enable_pause();
    int e0 = err_cnt;
    push_frame(2, 16'h7000);
    repeat (6) tick();
    bus_a.i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_rd", bus_a.o_rd, 0);
    end
    bus_a.i_enable = 1'b1;
    drain("enable_pause");
    chk("pause_err", err_cnt - e0, 0);
    chk("pause_bank_wrap", bus_a.o_wr_bank, 0);
  endtask

  task automatic test_async_reset();
    push_frame(0, 16'h8000);
    repeat (5) tick();
    #3 rstn = 1'b0;
    #1;
    chk("arst_wr", bus_a.o_mem_wr, 0);
    chk("arst_rd", bus_a.o_rd, 0);
    chk("arst_done_bank", bus_a.o_done_bank, 0);
    src.delete();
    exp_q.delete();
    pend = 1'b0;
    drive_src();
    repeat (3) tick();
    rstn = 1'b1;
    push_frame(0, 16'h8100);
    drain("after_reset");
    chk("arst_restart_bank", bus_a.o_wr_bank, 1);
  endtask

  initial begin
    rstn = 1'b0;
    bus_a.i_flush = 1'b0;
    bus_a.i_enable = 1'b1;
    bus_a.i_rd_lock = 1'b0; bus_a.i_rd_bank = '0;
    bus_b.i_rd_lock = 1'b0; bus_b.i_rd_bank = '0;
    drive_src();
    test_reset();
    test_clean_frames();
    test_garbage();
    test_early_sof();
    test_lock();
    test_flush();
    test_almostempty();
    test_enable_pause();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
